instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
Direct-mapped, read-only instruction cache between the core's instruction bus (upstream consumer) and instruction memory (downstream).
- On a hit it returns the word combinationally in the same cycle.
- On a miss it refills the whole line word-by-word over a simple request/response memory port, then serves the fetch.
- The core holds instruction_address stable while instruction_response is low.

Parameters:
ADDR_WIDTH, 32, byte-address width of both buses
LINES, 64, number of cache lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
instruction_address  input  ADDR_WIDTH  fetch byte address from core; bits [1:0] ignored
instruction_data  output  32  fetched word; valid only while instruction_response=1
instruction_response  output  1  high = hit, instruction_data valid this cycle
invalidate  input  1  one-cycle pulse: clear all valid bits
mem_read  output  1  refill word request to memory
mem_address  output  ADDR_WIDTH  word-aligned refill address
mem_read_data  input  32  memory word, valid when mem_response=1
mem_response  input  1  one-cycle acknowledge of the current request

Behaviour:
- Address split:
  - offset = addr[log2(WPL)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage:
  - valid[LINES], tag[LINES], data[LINES*WPL]
  - Register arrays with combinational read.
- Reset values (async assert):
  - valid all 0, state IDLE, mem_read 0, mem_address 0, word counter 0.
  - instruction_response 0 and instruction_data 0, because no line is valid.
- Hit: valid[index] && tag match && state==IDLE.
  - instruction_response=1 and instruction_data=data[index][offset] in the same cycle (0-cycle latency).
  - On a non-hit, instruction_response=0 and instruction_data=0.
- FSM states: IDLE, REFILL, FILL_DONE.
  - IDLE:
    - On a miss with invalidate=0, latch line_tag/line_index from instruction_address.
    - Set counter=0, go to REFILL.
    - mem_read=1, mem_address={tag,index,0,2'b00} from the next cycle.
  - REFILL:
    - Hold mem_read=1 and mem_address={line base, counter, 2'b00} stable until mem_response=1.
    - On mem_response: write mem_read_data into data[line_index][counter] and increment counter.
    - If counter==WPL-1: drop mem_read next cycle and go to FILL_DONE. Otherwise present the next word address next cycle, keeping mem_read high.
    - Any number of wait states is allowed. Back-to-back responses give one word per cycle.
  - FILL_DONE:
    - Set valid[line_index]=1 and tag[line_index]=line_tag, unless an invalidate occurred during the refill.
    - Return to IDLE. The hit is visible the following cycle.
- Miss penalty with zero-wait memory: 1 (IDLE→REFILL) + WPL + 1 (FILL_DONE) cycles before instruction_response rises.
- mem_response while mem_read=0 is ignored.
- Refill always fills the latched line. A changed instruction_address mid-refill does not abort it; response is driven only by the current address vs stored tags.
- Invalidate:
  - In IDLE/FILL_DONE: all valid bits are 0 next cycle, taking priority over the FILL_DONE set.
  - In REFILL: valid bits are cleared, the refill still completes on the bus, but the line is not marked valid.
  - Invalidate and a miss in the same IDLE cycle: the invalidate is serviced first and the refill starts on the following cycle.
- Reset mid-refill: mem_read drops immediately (async), FSM returns to IDLE, the partially written line stays invalid.
- No write path. Self-modifying code requires invalidate.

Test Plan:
1. Cold miss, LINES=64, WPL=4, zero-wait memory, addr 0x100 → mem_address sequence 0x100, 0x104, 0x108, 0x10C; instruction_response rises 6 cycles after the miss with data of 0x100.
2. After test 1, fetch 0x104, 0x108, 0x10C → instruction_response=1 in the same cycle each time with correct words; mem_read stays 0.
3. Conflict: fetch 0x100, then 0x500 (same index 16, different tag) → refill of 0x500..0x50C; fetching 0x100 again misses and refills.
4. Memory with 3 wait states per word → mem_address stable and mem_read high across waits; a spurious mem_response while mem_read=0 does not alter the array; fill completes after 4 acks.
5. Invalidate during the REFILL of 0x200 → refill completes on the bus, but the next fetch of 0x200 misses and issues a new refill.
6. Reset asserted mid-refill after 2 words → mem_read=0 immediately; after release, fetching the same address misses and refills from word 0.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with word-by-word line refill.
module instruction_cache #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINES          = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [31:0]           instruction_data,
  output logic                  instruction_response,
  input  logic                  invalidate,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           mem_read_data,
  input  logic                  mem_response
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam int unsigned SLOT_W = IDX_W + OFF_W;

  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS_PER_LINE];

  logic [TAG_W-1:0] line_tag;
  logic [IDX_W-1:0] line_index;
  logic [OFF_W-1:0] word_cnt;
  logic             inval_seen;

  logic [OFF_W-1:0]  addr_off;
  logic [IDX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [OFF_W-1:0]  cnt_next;
  logic              hit;
  logic              start_fill;
  logic              word_ack;
  logic              last_word;
  logic              set_valid;
  logic              unused_addr_bits;

  // Byte-address split; the two lowest bits select a byte and are not used.
  assign addr_off         = instruction_address[OFF_W+1:2];
  assign addr_idx         = instruction_address[SLOT_W+1:OFF_W+2];
  assign addr_tag         = instruction_address[ADDR_WIDTH-1:SLOT_W+2];
  assign unused_addr_bits = ^instruction_address[1:0];
  assign cnt_next         = word_cnt + OFF_W'(1);

  // Zero-latency lookup; the array is only trusted while no refill is in flight.
  assign hit = (state == IDLE) && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign instruction_response = hit;
  assign instruction_data     = hit ? data_q[SLOT_W'({addr_idx, addr_off})] : 32'h0;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    start_fill = 1'b0;
    word_ack   = 1'b0;
    last_word  = 1'b0;
    set_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!hit && !invalidate) begin
          start_fill = 1'b1;
          state_next = REFILL;
        end
      end
      REFILL: begin
        if (mem_read && mem_response) begin
          word_ack  = 1'b1;
          last_word = (word_cnt == OFF_W'(WORDS_PER_LINE - 1));
          if (last_word) state_next = FILL_DONE;
        end
      end
      FILL_DONE: begin
        set_valid  = !inval_seen && !invalidate;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Refill bookkeeping and the registered memory request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read    <= 1'b0;
      mem_address <= '0;
      word_cnt    <= '0;
      line_tag    <= '0;
      line_index  <= '0;
      inval_seen  <= 1'b0;
    end else begin
      if (start_fill) begin
        line_tag    <= addr_tag;
        line_index  <= addr_idx;
        word_cnt    <= '0;
        inval_seen  <= 1'b0;
        mem_read    <= 1'b1;
        mem_address <= {addr_tag, addr_idx, OFF_W'(0), 2'b00};
      end else if (word_ack) begin
        word_cnt <= cnt_next;
        if (last_word) mem_read    <= 1'b0;
        else           mem_address <= {line_tag, line_index, cnt_next, 2'b00};
      end
      if (state == REFILL && invalidate) inval_seen <= 1'b1;
    end
  end

  // Valid bits: invalidate wins over completing a fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          valid_q <= '0;
    else if (invalidate) valid_q <= '0;
    else if (set_valid)  valid_q[line_index] <= 1'b1;
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (set_valid) tag_q[line_index] <= line_tag;
    if (word_ack)  data_q[SLOT_W'({line_index, word_cnt})] <= mem_read_data;
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: directed fetches, a behavioural memory with wait states.
module tb_instruction_cache;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] instruction_address;
  logic [31:0]   instruction_data;
  logic          instruction_response;
  logic          invalidate;
  logic          mem_read;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_read_data = 32'h0;
  logic          mem_response  = 1'b0;

  instruction_cache #(.ADDR_WIDTH(AW), .LINES(64), .WORDS_PER_LINE(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction_address  (instruction_address),
    .instruction_data     (instruction_data),
    .instruction_response (instruction_response),
    .invalidate           (invalidate),
    .mem_read             (mem_read),
    .mem_address          (mem_address),
    .mem_read_data        (mem_read_data),
    .mem_response         (mem_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_exp_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned issue_cyc = 0;
  bit          fetch_active = 1'b0;
  int unsigned mem_wait = 0;
  int unsigned wcnt = 0;
  logic [31:0] held_addr = 32'h0;
  bit          spurious = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Response monitor: pops one expected fetch each time the DUT reports a hit.
  always @(negedge clk) begin
    if (!reset && fetch_active && instruction_response) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fetch_unexpected: response for %h with nothing expected", instruction_address);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("fetch_addr", instruction_address, e.addr);
        check("fetch_data", instruction_data, e.data);
        check("fetch_latency", 32'(cyc - issue_cyc), 32'(e.lat));
      end
      fetch_active = 1'b0;
    end
  end

  // Memory model: acks after mem_wait idle cycles, checks request order and stability.
  always @(negedge clk) begin
    mem_response  = 1'b0;
    mem_read_data = 32'h0;
    if (spurious) begin
      mem_response  = 1'b1;
      mem_read_data = 32'hDEAD_BEEF;
    end else if (mem_read) begin
      if (wcnt == 0) held_addr = mem_address;
      else           check("mem_addr_stable", mem_address, held_addr);
      if (wcnt == mem_wait) begin
        mem_response  = 1'b1;
        mem_read_data = {16'hC0DE, mem_address[15:0]};
        if (mem_exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_unexpected: request %h with nothing expected", mem_address);
        end else begin
          check("mem_addr", mem_address, mem_exp_q.pop_front());
        end
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) mem_exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input int unsigned lat);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.lat  = lat;
    exp_q.push_back(e);
    issue_cyc           = cyc;
    instruction_address = a;
    fetch_active        = 1'b1;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (fetch_active && n < budget) begin
      step();
      n++;
    end
    if (fetch_active) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: no response for %h within %0d cycles", instruction_address, budget);
      fetch_active = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    invalidate          = 1'b0;
    instruction_address = 32'h100;
    step();
    step();
    check("reset_response", 32'(instruction_response), 32'h0);
    check("reset_data", instruction_data, 32'h0);
    check("reset_mem_read", 32'(mem_read), 32'h0);
    check("reset_mem_address", mem_address, 32'h0);

    // Cold miss on 0x100 with zero-wait memory.
    reset = 1'b0;
    push_line(32'h100);
    issue(32'h100, 32'hC0DE_0100, 6);
    wait_done(40);

    // Hits on the rest of the line, no memory traffic.
    issue(32'h104, 32'hC0DE_0104, 0); wait_done(5);
    check("hit_mem_read", 32'(mem_read), 32'h0);
    issue(32'h108, 32'hC0DE_0108, 0); wait_done(5);
    issue(32'h10C, 32'hC0DE_010C, 0); wait_done(5);
    check("hit_mem_read", 32'(mem_read), 32'h0);

    // Conflict on index 16.
    push_line(32'h500);
    issue(32'h500, 32'hC0DE_0500, 6); wait_done(40);
    push_line(32'h100);
    issue(32'h100, 32'hC0DE_0100, 6); wait_done(40);
    issue(32'h10C, 32'hC0DE_010C, 0); wait_done(5);

    // Three wait states per word, then a spurious ack while idle.
    mem_wait = 3;
    push_line(32'h300);
    issue(32'h300, 32'hC0DE_0300, 18); wait_done(80);
    mem_wait = 0;
    spurious = 1'b1;
    step();
    step();
    spurious = 1'b0;
    check("spurious_mem_read", 32'(mem_read), 32'h0);
    step();
    issue(32'h304, 32'hC0DE_0304, 0); wait_done(5);
    issue(32'h300, 32'hC0DE_0300, 0); wait_done(5);

    // Invalidate during the refill of 0x200: refill completes, line not kept, refetched.
    push_line(32'h200);
    push_line(32'h200);
    issue(32'h200, 32'hC0DE_0200, 12);
    step();
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    wait_done(60);
    push_line(32'h100);
    issue(32'h100, 32'hC0DE_0100, 6); wait_done(40);
    issue(32'h208, 32'hC0DE_0208, 0); wait_done(5);

    // Invalidate coinciding with a miss in idle: refill starts one cycle later.
    push_line(32'h500);
    invalidate = 1'b1;
    issue(32'h504, 32'hC0DE_0504, 7);
    step();
    invalidate = 1'b0;
    wait_done(40);
    push_line(32'h200);
    issue(32'h208, 32'hC0DE_0208, 6); wait_done(40);

    // Reset after two refill words of 0x380.
    mem_exp_q.push_back(32'h380);
    mem_exp_q.push_back(32'h384);
    instruction_address = 32'h380;
    step();
    step();
    step();
    check("pre_reset_mem_read", 32'(mem_read), 32'h1);
    reset = 1'b1;
    #1;
    check("async_reset_mem_read", 32'(mem_read), 32'h0);
    check("async_reset_response", 32'(instruction_response), 32'h0);
    step();
    reset = 1'b0;
    push_line(32'h380);
    issue(32'h380, 32'hC0DE_0380, 6); wait_done(40);
    issue(32'h38C, 32'hC0DE_038C, 0); wait_done(5);
    issue(32'h10C, 32'hC0DE_010C, 6);
    push_line(32'h100);
    wait_done(40);

    step();
    check("fetch_queue_empty", 32'(exp_q.size()), 32'h0);
    check("mem_queue_empty", 32'(mem_exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
